hash_engine_stream_arbiter: RTL and testbench

- Shares one hash engine pipeline among NUM_STREAMS independent input streams.
- Grants the engine input to one stream per job. A job is a sequence of beats ending with a delim beat, and it is never interleaved with another job.
- Records the granted stream ID per job in an in-order tag FIFO.
- Steers the engine's in-order result beats back to the stream that owns the job at the FIFO head. Sits directly in front of and behind the hash engine.

---
 rtl/hash_engine_stream_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_hash_engine_stream_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_engine_stream_arbiter.sv
// rtl/hash_engine_stream_arbiter.sv - job-granular arbiter and result router around one shared hash engine
//
// Purpose:
//   Several independent request streams share a single in-order hash engine.
//   Ingress grants the engine input to one stream per job and holds the grant
//   until that job's delim beat. Each grant pushes the stream ID into an in-order
//   tag FIFO. Egress steers the engine's result beats to the stream whose tag is
//   at the FIFO head, and pops the tag on the result delim beat.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   cfg_stream_en   - per-stream arbitration enable, sampled only while idle
//   s_valid/s_ready/s_delim/s_data - per-stream request beats (data stream i at [i*IN_W +: IN_W])
//   e_valid/e_ready/e_delim/e_data - engine input (granted stream's beats)
//   r_valid/r_ready/r_delim/r_data - engine result beats (in job order)
//   d_valid/d_ready - per-stream result handshake
//   d_delim/d_data  - result delim/payload, broadcast to all streams
//   jobs_in_flight  - registered tag FIFO occupancy
//   busy            - a job is being fed in, or results are still owed
//   err_orphan      - sticky: a result beat showed up with no job outstanding

module hash_engine_stream_arbiter #(
    parameter int NUM_STREAMS = 4,
    parameter int SID_W       = 2,
    parameter int IN_W        = 288,
    parameter int OUT_W       = 1024,
    parameter int MAX_JOBS    = 8,
    parameter int CNT_W       = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [NUM_STREAMS-1:0]      cfg_stream_en,

    input  logic [NUM_STREAMS-1:0]      s_valid,
    output logic [NUM_STREAMS-1:0]      s_ready,
    input  logic [NUM_STREAMS-1:0]      s_delim,
    input  logic [NUM_STREAMS*IN_W-1:0] s_data,

    output logic                        e_valid,
    input  logic                        e_ready,
    output logic                        e_delim,
    output logic [IN_W-1:0]             e_data,

    input  logic                        r_valid,
    output logic                        r_ready,
    input  logic                        r_delim,
    input  logic [OUT_W-1:0]            r_data,

    output logic [NUM_STREAMS-1:0]      d_valid,
    input  logic [NUM_STREAMS-1:0]      d_ready,
    output logic                        d_delim,
    output logic [OUT_W-1:0]            d_data,

    output logic [CNT_W-1:0]            jobs_in_flight,
    output logic                        busy,
    output logic                        err_orphan
);

    localparam int PTR_W = CNT_W - 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [SID_W-1:0] r_rr_ptr;
    logic [SID_W-1:0] r_grant_id;
    logic [SID_W-1:0] r_tag_mem [MAX_JOBS];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err_orphan;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [NUM_STREAMS-1:0] w_eligible;
    logic                   w_pick_found;
    logic [SID_W-1:0]       w_pick_id;
    logic [SID_W-1:0]       w_idx;
    logic                   w_fifo_ne;
    logic [SID_W-1:0]       w_head;
    logic                   w_pop;
    logic                   w_room;
    logic                   w_push;
    logic                   w_job_done;

    assign w_eligible = s_valid & cfg_stream_en;
    assign w_fifo_ne  = (r_cnt != '0);
    assign w_head     = r_tag_mem[r_rd_ptr];

    // Round-robin search starting at r_rr_ptr; SID_W-bit addition wraps
    // naturally because NUM_STREAMS is a power of two.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        w_idx        = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            w_idx = r_rr_ptr + SID_W'(k);
            if (!w_pick_found && w_eligible[w_idx]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_idx;
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still take the
    // new tag: the slot being written is exactly the one being released.
    assign w_pop      = w_fifo_ne & r_valid & r_ready & r_delim;
    assign w_room     = (r_cnt < CNT_W'(MAX_JOBS)) | w_pop;
    assign w_push     = (r_state == ST_IDLE) & w_pick_found & w_room;
    assign w_job_done = (r_state == ST_LOCKED) & e_valid & e_ready & e_delim;

    // ------------------------------------------------------------------
    // Ingress: forward the granted stream only while LOCKED
    // ------------------------------------------------------------------
    always_comb begin
        e_valid = 1'b0;
        e_delim = 1'b0;
        e_data  = '0;
        s_ready = '0;
        if (r_state == ST_LOCKED) begin
            e_valid             = s_valid[r_grant_id];
            e_delim             = s_delim[r_grant_id];
            e_data              = s_data[int'(r_grant_id)*IN_W +: IN_W];
            s_ready[r_grant_id] = e_ready;
        end
    end

    // ------------------------------------------------------------------
    // Egress: zero-latency steering to the owner of the head job
    // ------------------------------------------------------------------
    always_comb begin
        d_valid = '0;
        r_ready = 1'b0;
        d_delim = 1'b0;
        d_data  = '0;
        if (w_fifo_ne) begin
            d_valid[w_head] = r_valid;
            r_ready         = d_ready[w_head];
            d_delim         = r_delim;
            d_data          = r_data;
        end
    end

    // ------------------------------------------------------------------
    // Ingress FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_push) begin
                        r_grant_id <= w_pick_id;
                        r_state    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_job_done) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= r_grant_id + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO pointers, occupancy and orphan flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (!w_fifo_ne && r_valid) r_err_orphan <= 1'b1;
        end
    end

    // Tag storage needs no reset: a slot is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_push) r_tag_mem[r_wr_ptr] <= w_pick_id;
    end

    assign jobs_in_flight = r_cnt;
    assign busy           = (r_state == ST_LOCKED) | w_fifo_ne;
    assign err_orphan     = r_err_orphan;

endmodule

// File: tb/tb_hash_engine_stream_arbiter.sv
// tb/tb_hash_engine_stream_arbiter.sv - self-checking bench for hash_engine_stream_arbiter
module tb_hash_engine_stream_arbiter;

    localparam int N     = 4;
    localparam int SID_W = 2;
    localparam int IN_W  = 288;
    localparam int OUT_W = 1024;
    localparam int MJ    = 8;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         cfg_stream_en;
    logic [N-1:0]         s_valid;
    logic [N-1:0]         s_ready;
    logic [N-1:0]         s_delim;
    logic [N*IN_W-1:0]    s_data;
    logic                 e_valid;
    logic                 e_ready;
    logic                 e_delim;
    logic [IN_W-1:0]      e_data;
    logic                 r_valid;
    logic                 r_ready;
    logic                 r_delim;
    logic [OUT_W-1:0]     r_data;
    logic [N-1:0]         d_valid;
    logic [N-1:0]         d_ready;
    logic                 d_delim;
    logic [OUT_W-1:0]     d_data;
    logic [CNT_W-1:0]     jobs_in_flight;
    logic                 busy;
    logic                 err_orphan;

    hash_engine_stream_arbiter #(
        .NUM_STREAMS(N), .SID_W(SID_W), .IN_W(IN_W), .OUT_W(OUT_W),
        .MAX_JOBS(MJ), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_stream_en(cfg_stream_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_delim(s_delim), .s_data(s_data),
        .e_valid(e_valid), .e_ready(e_ready), .e_delim(e_delim), .e_data(e_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_delim(r_delim), .r_data(r_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_delim(d_delim), .d_data(d_data),
        .jobs_in_flight(jobs_in_flight), .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: job owner list as a queue, plus arbitration status.
    bit m_locked;
    int m_gid;
    int m_rr;
    int m_q[$];
    bit m_err;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act[127:0], exp[127:0]);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_gid    = 0;
        m_rr     = 0;
        m_q.delete();
        m_err    = 1'b0;
    endtask

    task automatic model_check();
        logic [N-1:0] ex_sr;
        logic [N-1:0] ex_dv;
        logic         ex_rr;
        ex_sr = '0;
        ex_dv = '0;
        ex_rr = 1'b0;
        chk("e_valid", e_valid, m_locked ? s_valid[m_gid] : 1'b0);
        if (m_locked) begin
            chk("e_delim", e_delim, s_delim[m_gid]);
            chk("e_data", e_data, s_data[m_gid*IN_W +: IN_W]);
            if (e_ready) ex_sr[m_gid] = 1'b1;
        end
        chk("s_ready", s_ready, ex_sr);
        if (m_q.size() > 0) begin
            if (r_valid) ex_dv[m_q[0]] = 1'b1;
            ex_rr = d_ready[m_q[0]];
            chk("d_delim", d_delim, r_delim);
            chk("d_data", d_data, r_data);
        end
        chk("d_valid", d_valid, ex_dv);
        chk("r_ready", r_ready, ex_rr);
        chk("jobs_in_flight", jobs_in_flight, m_q.size());
        chk("busy", busy, m_locked || (m_q.size() != 0));
        chk("err_orphan", err_orphan, m_err);
    endtask

    task automatic model_update();
        logic [N-1:0] elig;
        bit pop;
        bit push;
        if (rst) begin
            model_reset();
            return;
        end
        pop  = 1'b0;
        push = 1'b0;
        if (m_q.size() > 0) pop = r_valid && d_ready[m_q[0]] && r_delim;
        else if (r_valid) m_err = 1'b1;
        if (m_locked) begin
            if (s_valid[m_gid] && e_ready && s_delim[m_gid]) begin
                m_locked = 1'b0;
                m_rr     = (m_gid + 1) % N;
            end
        end else begin
            elig = s_valid & cfg_stream_en;
            if (elig != 0 && (m_q.size() < MJ || pop)) begin
                for (int k = 0; k < N; k++) begin
                    if (!push && elig[(m_rr + k) % N]) begin
                        push     = 1'b1;
                        m_gid    = (m_rr + k) % N;
                        m_locked = 1'b1;
                    end
                end
            end
        end
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(m_gid);
    endtask

    // One clock: compare mid-cycle, then advance the model on the edge.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        cfg_stream_en = '0;
        s_valid       = '0;
        s_delim       = '0;
        s_data        = '0;
        e_ready       = 1'b0;
        r_valid       = 1'b0;
        r_delim       = 1'b0;
        r_data        = '0;
        d_ready       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < (N*IN_W)/32; i++) s_data[i*32 +: 32] = $urandom;
        for (int i = 0; i < OUT_W/32; i++)    r_data[i*32 +: 32] = $urandom;
    endtask

    logic [IN_W-1:0]  pd [3];
    logic [OUT_W-1:0] rd;
    int acc_id[$];
    int acc_cyc[$];
    int exp_order[5];

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            pd[i] = '0;
            for (int j = 0; j < IN_W/32; j++) pd[i][j*32 +: 32] = $urandom;
        end
        rd = '0;
        for (int j = 0; j < OUT_W/32; j++) rd[j*32 +: 32] = $urandom;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;

        // Reset state
        settle();
        chk("rst_e_valid", e_valid, 1'b0);
        chk("rst_jobs", jobs_in_flight, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_orphan, 1'b0);

        // Stream 2 sends a 3-beat job, engine returns 2 result beats
        do_reset();
        cfg_stream_en = 4'hF;
        d_ready       = 4'hF;
        e_ready       = 1'b1;
        s_valid       = 4'b0100;
        s_data[2*IN_W +: IN_W] = pd[0];
        settle();
        chk("t1_idle_e_valid", e_valid, 1'b0);
        chk("t1_idle_s_ready", s_ready, 4'b0000);
        tick();
        settle();
        chk("t1_jobs_1", jobs_in_flight, 1);
        chk("t1_s_ready", s_ready, 4'b0100);
        chk("t1_beat0", e_data, pd[0]);
        tick();
        s_data[2*IN_W +: IN_W] = pd[1];
        settle();
        chk("t1_beat1", e_data, pd[1]);
        tick();
        s_data[2*IN_W +: IN_W] = pd[2];
        s_delim = 4'b0100;
        settle();
        chk("t1_beat2", e_data, pd[2]);
        chk("t1_e_delim", e_delim, 1'b1);
        tick();
        s_valid = '0;
        s_delim = '0;
        r_valid = 1'b1;
        r_data  = rd;
        settle();
        chk("t1_res0_d_valid", d_valid, 4'b0100);
        chk("t1_res0_r_ready", r_ready, 1'b1);
        tick();
        r_delim = 1'b1;
        settle();
        chk("t1_res1_d_valid", d_valid, 4'b0100);
        chk("t1_res1_jobs", jobs_in_flight, 1);
        tick();
        r_valid = 1'b0;
        r_delim = 1'b0;
        settle();
        chk("t1_jobs_0", jobs_in_flight, 0);
        chk("t1_busy_0", busy, 1'b0);

        // All streams continuously offering single-beat jobs
        do_reset();
        cfg_stream_en = 4'hF;
        s_valid       = 4'hF;
        s_delim       = 4'hF;
        e_ready       = 1'b1;
        rand_data();
        for (int c = 0; c < 10; c++) begin
            settle();
            if (e_valid && e_ready) begin
                for (int i = 0; i < N; i++) if (s_ready[i]) acc_id.push_back(i);
                acc_cyc.push_back(c);
            end
            tick();
        end
        chk("t2_accept_count", acc_id.size(), 5);
        for (int i = 0; i < 5 && i < acc_id.size(); i++) begin
            chk("t2_grant_order", acc_id[i], exp_order[i]);
            chk("t2_accept_cycle", acc_cyc[i], 2*i + 1);
        end
        settle();
        chk("t2_jobs_5", jobs_in_flight, 5);

        // Tag FIFO full: 9th job stalls until a result pops
        do_reset();
        cfg_stream_en = 4'hF;
        s_valid       = 4'b0001;
        s_delim       = 4'b0001;
        e_ready       = 1'b1;
        d_ready       = 4'hF;
        for (int c = 0; c < 20; c++) tick();
        settle();
        chk("t3_jobs_full", jobs_in_flight, 8);
        chk("t3_stalled", e_valid, 1'b0);
        chk("t3_busy", busy, 1'b1);
        r_valid = 1'b1;
        r_delim = 1'b1;
        r_data  = rd;
        settle();
        chk("t3_pop_r_ready", r_ready, 1'b1);
        chk("t3_pop_d_valid", d_valid, 4'b0001);
        tick();
        r_valid = 1'b0;
        r_delim = 1'b0;
        settle();
        chk("t3_jobs_still_8", jobs_in_flight, 8);
        chk("t3_granted_same_cycle", e_valid, 1'b1);

        // Stream 1 disabled mid-job with e_ready toggling
        do_reset();
        cfg_stream_en = 4'hF;
        s_valid       = 4'b0010;
        e_ready       = 1'b1;
        rand_data();
        tick();
        cfg_stream_en = 4'b1101;
        settle();
        chk("t4_e_valid", e_valid, 1'b1);
        tick();
        e_ready = 1'b0;
        settle();
        chk("t4_stall_s_ready", s_ready, 4'b0000);
        chk("t4_stall_e_valid", e_valid, 1'b1);
        tick();
        e_ready = 1'b1;
        s_valid = 4'b0000;
        settle();
        chk("t4_tracks_s_valid", e_valid, 1'b0);
        tick();
        s_valid = 4'b0010;
        s_delim = 4'b0010;
        settle();
        chk("t4_last_e_delim", e_delim, 1'b1);
        chk("t4_last_s_ready", s_ready, 4'b0010);
        tick();
        for (int c = 0; c < 3; c++) tick();
        settle();
        chk("t4_no_regrant_jobs", jobs_in_flight, 1);
        chk("t4_no_regrant_e_valid", e_valid, 1'b0);
        s_valid = 4'b1010;
        s_delim = 4'b0000;
        tick();
        settle();
        chk("t4_next_is_3", s_ready, 4'b1000);

        // Result for stream 3 held back by d_ready[3]
        do_reset();
        cfg_stream_en = 4'hF;
        s_valid       = 4'b1000;
        s_delim       = 4'b1000;
        e_ready       = 1'b1;
        tick();
        tick();
        s_valid = '0;
        s_delim = '0;
        r_valid = 1'b1;
        r_delim = 1'b1;
        r_data  = rd;
        d_ready = 4'b0111;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("t5_hold_r_ready", r_ready, 1'b0);
            chk("t5_hold_d_valid", d_valid, 4'b1000);
            chk("t5_hold_d_data", d_data, rd);
            tick();
        end
        d_ready = 4'b1000;
        settle();
        chk("t5_release_r_ready", r_ready, 1'b1);
        tick();
        r_valid = 1'b0;
        settle();
        chk("t5_jobs_0", jobs_in_flight, 0);

        // Orphan result, then asynchronous reset mid-job
        do_reset();
        d_ready = 4'hF;
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        settle();
        chk("t6_orphan_set", err_orphan, 1'b1);
        tick(); tick(); tick();
        chk("t6_orphan_sticky", err_orphan, 1'b1);
        cfg_stream_en = 4'hF;
        s_valid       = 4'b0001;
        e_ready       = 1'b1;
        tick();
        tick();
        settle();
        chk("t6_mid_job", e_valid, 1'b1);
        rst = 1'b1;
        model_reset();
        settle();
        chk("t6_arst_e_valid", e_valid, 1'b0);
        chk("t6_arst_s_ready", s_ready, 4'b0000);
        chk("t6_arst_jobs", jobs_in_flight, 0);
        chk("t6_arst_busy", busy, 1'b0);
        chk("t6_arst_err", err_orphan, 1'b0);
        chk("t6_arst_r_ready", r_ready, 1'b0);
        tick();
        rst = 1'b0;

        // Randomized traffic against the model
        do_reset();
        cfg_stream_en = 4'hF;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) cfg_stream_en = 4'($urandom) | 4'($urandom);
            s_valid = 4'($urandom);
            s_delim = 4'($urandom) & 4'($urandom);
            e_ready = ($urandom_range(0, 3) != 0);
            r_valid = ($urandom_range(0, 2) != 0);
            r_delim = ($urandom_range(0, 3) == 0);
            d_ready = 4'($urandom) | 4'($urandom);
            rand_data();
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
